// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch core: up/down run mode, latched pause, per-field adjust,
// configurable minute-tens full-scale, wrap pulse and adjust blink phase.
module stopwatch_bcd_counter #(
    parameter int unsigned MIN_TENS_MAX = 9,
    parameter int unsigned DOWN_EN      = 0,
    parameter int unsigned PAUSE_TOGGLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_run,
    input  logic       tick_adj,
    input  logic       pause,
    input  logic       adjust,
    input  logic       select,
    input  logic       dir,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       paused,
    output logic       wrap,
    output logic       adj_blink
);

    localparam logic [3:0] MT_MAX  = 4'(MIN_TENS_MAX);
    localparam bit         DOWN_OK = (DOWN_EN != 0);
    localparam bit         TOGGLE  = (PAUSE_TOGGLE != 0);

    logic [3:0] min1_q, min1_d;
    logic [3:0] min0_q, min0_d;
    logic [3:0] sec1_q, sec1_d;
    logic [3:0] sec0_q, sec0_d;
    logic       paused_q, paused_d;
    logic       wrap_q, wrap_d;
    logic       blink_q, blink_d;

    logic count_down_c;
    logic run_c;

    assign count_down_c = DOWN_OK && dir;
    // Tick is qualified by the paused value before this cycle's pause update.
    assign run_c        = !paused_q && tick_run;

    // Next-state: adjust has priority over pause/run; digits stay legal BCD.
    always_comb begin
        min1_d   = min1_q;
        min0_d   = min0_q;
        sec1_d   = sec1_q;
        sec0_d   = sec0_q;
        paused_d = paused_q;
        wrap_d   = 1'b0;
        blink_d  = blink_q;

        if (adjust) begin
            if (tick_adj) begin
                blink_d = ~blink_q;
                if (select) begin
                    if (sec0_q == 4'd9) begin
                        sec0_d = 4'd0;
                        sec1_d = (sec1_q == 4'd5) ? 4'd0 : sec1_q + 4'd1;
                    end else begin
                        sec0_d = sec0_q + 4'd1;
                    end
                end else begin
                    if (min0_q == 4'd9) begin
                        min0_d = 4'd0;
                        min1_d = (min1_q == MT_MAX) ? 4'd0 : min1_q + 4'd1;
                    end else begin
                        min0_d = min0_q + 4'd1;
                    end
                end
            end
        end else begin
            blink_d = 1'b0;
            if (run_c) begin
                if (count_down_c) begin
                    if (sec0_q != 4'd0) begin
                        sec0_d = sec0_q - 4'd1;
                    end else begin
                        sec0_d = 4'd9;
                        if (sec1_q != 4'd0) begin
                            sec1_d = sec1_q - 4'd1;
                        end else begin
                            sec1_d = 4'd5;
                            if (min0_q != 4'd0) begin
                                min0_d = min0_q - 4'd1;
                            end else begin
                                min0_d = 4'd9;
                                if (min1_q != 4'd0) begin
                                    min1_d = min1_q - 4'd1;
                                end else begin
                                    min1_d = MT_MAX;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    if (sec0_q != 4'd9) begin
                        sec0_d = sec0_q + 4'd1;
                    end else begin
                        sec0_d = 4'd0;
                        if (sec1_q != 4'd5) begin
                            sec1_d = sec1_q + 4'd1;
                        end else begin
                            sec1_d = 4'd0;
                            if (min0_q != 4'd9) begin
                                min0_d = min0_q + 4'd1;
                            end else begin
                                min0_d = 4'd0;
                                if (min1_q != MT_MAX) begin
                                    min1_d = min1_q + 4'd1;
                                end else begin
                                    min1_d = 4'd0;
                                    wrap_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            if (TOGGLE) begin
                paused_d = paused_q ^ pause;
            end else begin
                paused_d = pause;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min1_q   <= 4'd0;
            min0_q   <= 4'd0;
            sec1_q   <= 4'd0;
            sec0_q   <= 4'd0;
            paused_q <= 1'b0;
            wrap_q   <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            min1_q   <= min1_d;
            min0_q   <= min0_d;
            sec1_q   <= sec1_d;
            sec0_q   <= sec0_d;
            paused_q <= paused_d;
            wrap_q   <= wrap_d;
            blink_q  <= blink_d;
        end
    end

    assign min1      = min1_q;
    assign min0      = min0_q;
    assign sec1      = sec1_q;
    assign sec0      = sec0_q;
    assign paused    = paused_q;
    assign wrap      = wrap_q;
    assign adj_blink = blink_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: two configurations share one stimulus stream,
// a seconds-count model is compared every cycle, plus literal spot checks.
module tb_stopwatch_bcd_counter;

    localparam int unsigned A_MTM = 9;
    localparam int unsigned B_MTM = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_run = 1'b0, tick_adj = 1'b0, pause = 1'b0;
    logic adjust = 1'b0, select = 1'b0, dir = 1'b0;

    logic [3:0] a_min1, a_min0, a_sec1, a_sec0;
    logic       a_paused, a_wrap, a_blink;
    logic [3:0] b_min1, b_min0, b_sec1, b_sec0;
    logic       b_paused, b_wrap, b_blink;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(.MIN_TENS_MAX(A_MTM), .DOWN_EN(1), .PAUSE_TOGGLE(1)) dut_a (
        .clk(clk), .reset(reset), .tick_run(tick_run), .tick_adj(tick_adj),
        .pause(pause), .adjust(adjust), .select(select), .dir(dir),
        .min1(a_min1), .min0(a_min0), .sec1(a_sec1), .sec0(a_sec0),
        .paused(a_paused), .wrap(a_wrap), .adj_blink(a_blink)
    );

    stopwatch_bcd_counter #(.MIN_TENS_MAX(B_MTM), .DOWN_EN(0), .PAUSE_TOGGLE(0)) dut_b (
        .clk(clk), .reset(reset), .tick_run(tick_run), .tick_adj(tick_adj),
        .pause(pause), .adjust(adjust), .select(select), .dir(dir),
        .min1(b_min1), .min0(b_min0), .sec1(b_sec1), .sec0(b_sec0),
        .paused(b_paused), .wrap(b_wrap), .adj_blink(b_blink)
    );

    logic [18:0] a_vec, b_vec;
    assign a_vec = {a_min1, a_min0, a_sec1, a_sec0, a_paused, a_wrap, a_blink};
    assign b_vec = {b_min1, b_min0, b_sec1, b_sec0, b_paused, b_wrap, b_blink};

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Model: the count is a plain number of seconds; digits derived by division.
    int tot[2];
    bit m_paused[2];
    bit m_wrap[2];
    bit m_blink[2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            tot[i] = 0; m_paused[i] = 0; m_wrap[i] = 0; m_blink[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int mtm, nmin, full, mm, ss;
        bit down_en, tog;
        mtm     = (i == 0) ? int'(A_MTM) : int'(B_MTM);
        down_en = (i == 0);
        tog     = (i == 0);
        nmin    = mtm * 10 + 10;
        full    = nmin * 60 - 1;
        m_wrap[i] = 0;
        if (adjust) begin
            if (tick_adj) begin
                m_blink[i] = ~m_blink[i];
                mm = tot[i] / 60;
                ss = tot[i] % 60;
                if (select) ss = (ss + 1) % 60;
                else        mm = (mm + 1) % nmin;
                tot[i] = mm * 60 + ss;
            end
        end else begin
            m_blink[i] = 0;
            if (!m_paused[i] && tick_run) begin
                if (down_en && dir) begin
                    if (tot[i] == 0) begin tot[i] = full; m_wrap[i] = 1; end
                    else tot[i] = tot[i] - 1;
                end else begin
                    if (tot[i] == full) begin tot[i] = 0; m_wrap[i] = 1; end
                    else tot[i] = tot[i] + 1;
                end
            end
            m_paused[i] = tog ? (m_paused[i] ^ pause) : pause;
        end
    endtask

    function automatic logic [18:0] model_vec(input int i);
        int mm, ss;
        mm = tot[i] / 60;
        ss = tot[i] % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                m_paused[i], m_wrap[i], m_blink[i]};
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk or posedge reset) begin
        if (reset) model_clear();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Per-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_cycle", 32'(a_vec), 32'(model_vec(0)));
            check("b_cycle", 32'(b_vec), 32'(model_vec(1)));
        end
    end

    task automatic step(input bit tr, input bit ta, input bit ps);
        tick_run = tr; tick_adj = ta; pause = ps;
        @(posedge clk);
        #1;
        tick_run = 1'b0; tick_adj = 1'b0; pause = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check("async_reset_a", 32'(a_vec), 32'h0);
        check("async_reset_b", 32'(b_vec), 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        check("reset_state_a", 32'(a_vec), 32'h0);
        check("reset_state_b", 32'(b_vec), 32'h0);

        // 61 ticks -> 01:01, then async reset mid-count.
        repeat (61) step(1, 0, 0);
        check("run61_a", 32'(a_vec[18:3]), 32'h0101);
        check("run61_b", 32'(b_vec[18:3]), 32'h0101);
        pulse_reset();

        // Full-scale wrap: B at 29:59, A at 99:59.
        repeat (1799) step(1, 0, 0);
        check("b_2959", 32'(b_vec[18:3]), 32'h2959);
        step(1, 0, 0);
        check("b_wrap_digits", 32'(b_vec[18:3]), 32'h0000);
        check("b_wrap_pulse", 32'(b_wrap), 32'h1);
        check("a_3000", 32'(a_vec[18:1]), {16'h3000, 2'b00});
        step(0, 0, 0);
        check("b_wrap_one_cycle", 32'(b_wrap), 32'h0);
        repeat (4199) step(1, 0, 0);
        check("a_9959", 32'(a_vec[18:3]), 32'h9959);
        step(1, 0, 0);
        check("a_wrap", 32'(a_vec[18:1]), {16'h0000, 2'b01});
        step(0, 0, 0);
        check("a_wrap_one_cycle", 32'(a_wrap), 32'h0);

        // Down count (A honours dir, B ignores it).
        pulse_reset();
        dir = 1'b1;
        step(1, 0, 0);
        check("a_down_wrap", 32'(a_vec[18:1]), {16'h9959, 2'b01});
        check("b_dir_ignored", 32'(b_vec[18:1]), {16'h0001, 2'b00});
        repeat (3) step(1, 0, 0);
        check("a_down_9956", 32'(a_vec[18:3]), 32'h9956);
        dir = 1'b0;

        // Pause toggle with simultaneous tick.
        pulse_reset();
        repeat (5) step(1, 0, 0);
        step(1, 0, 1);
        check("a_pause_tick", 32'(a_vec[18:2]), {16'h0006, 1'b1});
        repeat (10) step(1, 0, 0);
        check("a_paused_hold", 32'(a_vec[18:2]), {16'h0006, 1'b1});
        step(0, 0, 1);
        check("a_unpause", 32'(a_paused), 32'h0);
        step(1, 0, 0);
        check("a_resume", 32'(a_vec[18:3]), 32'h0007);

        // Adjust: set 12:58, then seconds +3 and minutes +2.
        pulse_reset();
        adjust = 1'b1; select = 1'b0;
        repeat (12) step(0, 1, 0);
        select = 1'b1;
        repeat (58) step(0, 1, 0);
        adjust = 1'b0;
        step(0, 0, 0);
        check("a_1258", 32'(a_vec[18:0]), {16'h1258, 3'b000});
        adjust = 1'b1; select = 1'b1;
        step(1, 1, 0);
        check("blink1", 32'(a_blink), 32'h1);
        step(1, 1, 0);
        check("blink2", 32'(a_blink), 32'h0);
        step(1, 1, 0);
        check("blink3", 32'(a_blink), 32'h1);
        check("a_1201", 32'(a_vec[18:3]), 32'h1201);
        select = 1'b0;
        repeat (2) step(0, 1, 0);
        check("a_1401", 32'(a_vec[18:3]), 32'h1401);
        adjust = 1'b0;
        step(0, 0, 0);
        check("blink_clear", 32'(a_blink), 32'h0);
        step(1, 0, 0);
        check("a_1402", 32'(a_vec[18:3]), 32'h1402);

        // Minutes wrap in adjust; pause ignored during adjust.
        step(0, 0, 1);
        check("a_paused_set", 32'(a_paused), 32'h1);
        adjust = 1'b1; select = 1'b0;
        repeat (85) step(0, 1, 0);
        check("a_9902", 32'(a_vec[18:3]), 32'h9902);
        step(0, 0, 1);
        check("a_pause_ignored", 32'(a_paused), 32'h1);
        step(1, 1, 0);
        check("a_min_wrap", 32'(a_vec[18:1]), {16'h0002, 2'b10});
        adjust = 1'b0;
        step(1, 0, 0);
        check("a_exit_adjust", 32'(a_vec[18:0]), {16'h0002, 3'b100});

        repeat (2) step(0, 0, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
